bam_seq_divider: RTL and testbench

//   Iterative unsigned restoring divider: inverse of the BAM multiplier path.

---
 rtl/bam_seq_divider_if.sv | 33 +++
 rtl/bam_seq_divider.sv | 122 ++++++++++++
 tb/tb_bam_seq_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bam_seq_divider_if.sv
// ============================================================================
// Module      : bam_seq_divider_if
// Description : Valid/ready operand and result bundle for bam_seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bam_seq_divider_if #(
    parameter int PW = 16,
    parameter int WW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] dividend;
    logic [WW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] quotient;
    logic [WW-1:0] remainder;
    logic          div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/bam_seq_divider.sv
// ============================================================================
// Module      : bam_seq_divider
// Description : Iterative unsigned restoring divider, one quotient bit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bam_seq_divider #(
    parameter int DW = 8,
    parameter int WW = 8,
    parameter int PW = DW + WW
) (
    input  wire                 clk,
    input  wire                 rst,
    bam_seq_divider_if.slave    bus
);
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(PW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] dvd_q, dvd_d;
    logic [WW-1:0] dsr_q, dsr_d;
    logic [WW:0]   rem_q, rem_d;
    logic [PW-1:0] quo_q, quo_d;
    logic          dz_q, dz_d;

    logic [WW:0]   w_shift;
    logic          w_fits;

    // Partial remainder carries one extra bit so the trial shift never overflows.
    assign w_shift = {rem_q[WW-1:0], dvd_q[PW-1]};
    assign w_fits  = (w_shift >= {1'b0, dsr_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dz_d    = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = {1'b0, bus.dividend[WW-1:0]};
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dvd_d   = bus.dividend;
                        dsr_d   = bus.divisor;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                dvd_d = {dvd_q[PW-2:0], 1'b0};
                if (w_fits) begin
                    rem_d = w_shift - {1'b0, dsr_q};
                    quo_d = {quo_q[PW-2:0], 1'b1};
                end else begin
                    rem_d = w_shift;
                    quo_d = {quo_q[PW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q[WW-1:0];
    assign bus.div_zero  = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_bam_seq_divider.sv
// ============================================================================
// Module      : tb_bam_seq_divider
// Description : Self-checking bench for bam_seq_divider against a divide model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bam_seq_divider;
    localparam int C_DW = 8;
    localparam int C_WW = 8;
    localparam int C_PW = C_DW + C_WW;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bam_seq_divider_if #(.PW(C_PW), .WW(C_WW)) bus ();

    bam_seq_divider #(.DW(C_DW), .WW(C_WW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Model: plain integer divide, with the defined divide-by-zero result.
    task automatic model(input logic [C_PW-1:0] a, input logic [C_WW-1:0] b,
                         output logic [C_PW-1:0] q, output logic [C_WW-1:0] r,
                         output logic dz);
        if (b == 0) begin
            q  = {C_PW{1'b1}};
            r  = a[C_WW-1:0];
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = C_WW'(a % b);
            dz = 1'b0;
        end
    endtask

    // Runs one operation end to end; garbage=1 keeps in_valid high with fresh
    // random operands while the divider is busy.
    task automatic run_op(input logic [C_PW-1:0] a, input logic [C_WW-1:0] b,
                          input bit garbage, input int stall, input string tag);
        logic [C_PW-1:0] eq;
        logic [C_WW-1:0] er;
        logic            edz;
        logic [C_PW-1:0] q0;
        logic [C_WW-1:0] r0;
        logic            dz0;
        int              lat;
        int              bound;
        model(a, b, eq, er, edz);

        bound = 0;
        while (!bus.in_ready && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        check({tag, " in_ready before op"}, 32'(bus.in_ready), 32'd1);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        lat = 1;
        #1;
        if (garbage) begin
            bus.dividend = C_PW'($urandom);
            bus.divisor  = C_WW'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (garbage) begin
                bus.dividend = C_PW'($urandom);
                bus.divisor  = C_WW'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(C_PW + 1));
        check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, " div_zero"}, 32'(bus.div_zero), 32'(edz));

        q0  = bus.quotient;
        r0  = bus.remainder;
        dz0 = bus.div_zero;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " stall in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, " stall hold"}, {7'd0, dz0, r0, q0},
                  {7'd0, bus.div_zero, bus.remainder, bus.quotient});
        end

        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid after pop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready after pop"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [C_PW-1:0] a;
        logic [C_WW-1:0] b;
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        #12;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset quotient", 32'(bus.quotient), 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset div_zero", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd1000, 8'd7, 1'b0, 0, "1000/7");
        run_op(16'hFFFF, 8'h01, 1'b0, 0, "FFFF/1");
        run_op(16'hFFFF, 8'hFF, 1'b0, 0, "FFFF/FF");
        run_op(16'h1234, 8'h00, 1'b0, 0, "1234/0");
        run_op(16'd0, 8'd9, 1'b0, 0, "0/9");
        run_op(16'd40000, 8'd123, 1'b0, 5, "stall5");
        run_op(16'd777, 8'd5, 1'b1, 0, "busy_ignore");

        // Abort mid-operation with an asynchronous reset pulse.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'd50000;
        bus.divisor  = 8'd13;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (C_PW + 2) begin
            @(negedge clk);
            check("abort no result", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'd50000, 8'd13, 1'b0, 0, "50000/13");

        for (int i = 0; i < 500; i++) begin
            a = C_PW'($urandom);
            b = C_WW'($urandom);
            case ($urandom_range(0, 9))
                0: b = 8'd1;
                1: b = 8'd255;
                2: a = '0;
                3: b = 8'd0;
                4: a = {C_PW{1'b1}};
                default: ;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
